// File: rtl/conv_pkg.sv
// Shared defaults and state encoding for the convolution result streamer.
package conv_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } stream_state_e;

    // Words buffered plus the read in flight, less the beat leaving this cycle.
    function automatic logic [2:0] occupancy(input logic [1:0] count,
                                             input logic       inflight,
                                             input logic       pop);
        return {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/conv_rd_fifo2.sv
// Two-entry FIFO that absorbs Z read data so the stream can run at one beat per cycle.
module conv_rd_fifo2 #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        count_o
);

    logic [DATA_W-1:0] mem_q [2];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push_i;
        rd_ptr_d = rd_ptr_q ^ pop_i;
        count_d  = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    // Push and pop on a full FIFO overwrite the slot being vacated by the head.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= wdata_i;
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/conv_result_streamer.sv
// Drains result memory Z as a valid/ready stream once the convolution controller is done,
// hiding the one-cycle Z read latency behind a two-entry buffer.
module conv_result_streamer
    import conv_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [ADDR_W:0]   size_Z,
    output logic              z_rd_en,
    output logic [ADDR_W-1:0] z_addr,
    input  logic [DATA_W-1:0] z_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    stream_state_e   state_q, state_d;
    logic [ADDR_W:0] size_q, size_d;
    logic [ADDR_W:0] rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0] beat_cnt_q, beat_cnt_d;
    logic            inflight_q, inflight_d;

    logic            issue;
    logic            pop;
    logic [ADDR_W:0] last_idx;
    logic            fifo_full;
    logic            fifo_empty;
    logic [1:0]      fifo_count;

    conv_rd_fifo2 #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (rstn),
        .push_i  (inflight_q),
        .wdata_i (z_rdata),
        .pop_i   (pop),
        .rdata_o (out_data),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign out_valid = !fifo_empty;
    assign pop       = out_valid && out_ready;
    assign last_idx  = size_q - {{ADDR_W{1'b0}}, 1'b1};
    assign out_last  = out_valid && (beat_cnt_q == last_idx);

    // A new read is allowed only if its data is guaranteed a free slot on arrival.
    assign issue = (state_q == ST_RUN) && (rd_cnt_q < size_q)
                && (occupancy(fifo_count, inflight_q, pop) < 3'd2);

    assign z_rd_en = issue;
    assign z_addr  = rd_cnt_q[ADDR_W-1:0];
    assign busy    = (state_q == ST_RUN);
    assign done    = (state_q == ST_FIN);

    always_comb begin
        state_d    = state_q;
        size_d     = size_q;
        rd_cnt_d   = rd_cnt_q + {{ADDR_W{1'b0}}, issue};
        beat_cnt_d = beat_cnt_q + {{ADDR_W{1'b0}}, pop};
        inflight_d = issue;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    size_d     = size_Z;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (size_Z == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (pop && out_last) begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            size_q     <= '0;
            rd_cnt_q   <= '0;
            beat_cnt_q <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            size_q     <= size_d;
            rd_cnt_q   <= rd_cnt_d;
            beat_cnt_q <= beat_cnt_d;
            inflight_q <= inflight_d;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
        !(inflight_q && fifo_full && !pop));

endmodule

// File: tb/tb_conv_result_streamer.sv
// Scoreboard bench for conv_result_streamer: expected beats queued at start, monitor checks on negedge.
module tb_conv_result_streamer;

    localparam int DW = 16;
    localparam int AW = 6;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   size_Z = '0;
    logic          z_rd_en;
    logic [AW-1:0] z_addr;
    logic [DW-1:0] z_rdata = '0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;

    conv_result_streamer #(
        .DATA_W (DW),
        .ADDR_W (AW)
    ) dut (
        .clk       (clk),
        .rstn      (rstn),
        .start     (start),
        .size_Z    (size_Z),
        .z_rd_en   (z_rd_en),
        .z_addr    (z_addr),
        .z_rdata   (z_rdata),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] zmem [64];
    always @(posedge clk) begin
        if (z_rd_en) z_rdata <= zmem[z_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    beat_t sb[$];
    int tests = 0;
    int fails = 0;

    int rd_n, beat_n, valid_n, busy_n, done_n;
    int first_rd_cyc, last_rd_cyc, last_rd_addr, first_valid_cyc, last_beat_cyc, done_cyc;
    int exp_addr, cur_size;
    bit prev_stall;
    logic [DW-1:0] prev_data;

    bit       ready_pat_en = 1'b0;
    int       pat_idx = 0;
    bit [5:0] ready_pat = 6'b101001;

    function automatic void check(string name, longint act, longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic clear_stats();
        rd_n = 0; beat_n = 0; valid_n = 0; busy_n = 0; done_n = 0;
        first_rd_cyc = -1; last_rd_cyc = -1; last_rd_addr = -1;
        first_valid_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
        exp_addr = 0; prev_stall = 1'b0;
    endtask

    task automatic check_outputs_zero(string tag);
        check({tag, "_z_rd_en"}, z_rd_en, 0);
        check({tag, "_z_addr"}, z_addr, 0);
        check({tag, "_out_valid"}, out_valid, 0);
        check({tag, "_out_data"}, out_data, 0);
        check({tag, "_out_last"}, out_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    task automatic start_drain(input int n, output int t);
        for (int i = 0; i < n; i++) begin
            beat_t b;
            b.data = zmem[i];
            b.last = (i == n - 1);
            sb.push_back(b);
        end
        cur_size = n;
        clear_stats();
        @(posedge clk); #1;
        start = 1'b1;
        size_Z = n[AW:0];
        t = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        size_Z = 7'd3;
    endtask

    task automatic wait_done(input int budget);
        int n0;
        n0 = done_n;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk); #1;
            if (done_n > n0) break;
        end
        check("done_within_budget", done_n > n0, 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Consumer ready: constant 1 or the repeating 1,0,0,1,0,1 pattern.
    initial begin
        forever begin
            @(posedge clk); #1;
            out_ready = ready_pat_en ? ready_pat[pat_idx % 6] : 1'b1;
            pat_idx++;
        end
    end

    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (rstn) begin
                if (done) begin
                    done_n++;
                    done_cyc = cyc;
                end
                if (busy) begin
                    busy_n++;
                    check("occupancy_le2", (rd_n - beat_n) <= 2, 1);
                end
                if (z_rd_en) begin
                    check("rd_addr", z_addr, exp_addr);
                    check("rd_in_range", exp_addr < cur_size, 1);
                    exp_addr++;
                    if (rd_n == 0) first_rd_cyc = cyc;
                    rd_n++;
                    last_rd_cyc = cyc;
                    last_rd_addr = int'(z_addr);
                end
                if (out_last) check("last_implies_valid", out_valid, 1);
                if (prev_stall) begin
                    check("stall_valid_hold", out_valid, 1);
                    check("stall_data_hold", out_data, prev_data);
                end
                if (out_valid) begin
                    if (valid_n == 0) first_valid_cyc = cyc;
                    valid_n++;
                end
                if (out_valid && out_ready) begin
                    check("sb_nonempty_on_beat", sb.size() > 0, 1);
                    if (sb.size() > 0) begin
                        e = sb.pop_front();
                        check("beat_data", out_data, e.data);
                        check("beat_last", out_last, e.last);
                    end
                    beat_n++;
                    last_beat_cyc = cyc;
                end
                prev_stall = out_valid && !out_ready;
                prev_data = out_data;
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        for (int i = 0; i < 64; i++) zmem[i] = '0;
        clear_stats();
        cur_size = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // size 5, ready always high: exact cycle timing
        for (int i = 0; i < 5; i++) zmem[i] = 16'(10 + i);
        start_drain(5, t);
        wait_done(40);
        check("t1_first_rd_cyc", first_rd_cyc, t + 1);
        check("t1_last_rd_cyc", last_rd_cyc, t + 5);
        check("t1_last_rd_addr", last_rd_addr, 4);
        check("t1_first_valid_cyc", first_valid_cyc, t + 3);
        check("t1_last_beat_cyc", last_beat_cyc, t + 7);
        check("t1_done_cyc", done_cyc, t + 8);
        check("t1_done_n", done_n, 1);
        check("t1_beats", beat_n, 5);
        check("t1_reads", rd_n, 5);
        check("t1_busy_cycles", busy_n, 7);
        check("t1_sb_empty", sb.size(), 0);

        // size 8 with back-pressure pattern
        for (int i = 0; i < 8; i++) zmem[i] = 16'(16'h0100 + i * 7);
        pat_idx = 0;
        ready_pat_en = 1'b1;
        start_drain(8, t);
        wait_done(200);
        ready_pat_en = 1'b0;
        check("t2_beats", beat_n, 8);
        check("t2_reads", rd_n, 8);
        check("t2_done_n", done_n, 1);
        check("t2_sb_empty", sb.size(), 0);

        // size 0: no reads, no beats, done next cycle
        start_drain(0, t);
        wait_done(20);
        check("t3_reads", rd_n, 0);
        check("t3_valids", valid_n, 0);
        check("t3_busy_cycles", busy_n, 0);
        check("t3_done_cyc", done_cyc, t + 1);
        check("t3_done_n", done_n, 1);

        // full depth 64, back-to-back
        for (int i = 0; i < 64; i++) zmem[i] = 16'(16'hA000 + i * 3);
        start_drain(64, t);
        wait_done(300);
        check("t4_beats", beat_n, 64);
        check("t4_valid_cycles", valid_n, 64);
        check("t4_last_rd_addr", last_rd_addr, 63);
        check("t4_last_rd_cyc", last_rd_cyc, t + 64);
        check("t4_first_valid_cyc", first_valid_cyc, t + 3);
        check("t4_last_beat_cyc", last_beat_cyc, t + 66);
        check("t4_done_cyc", done_cyc, t + 67);
        check("t4_sb_empty", sb.size(), 0);

        // second start mid-drain must be ignored
        for (int i = 0; i < 6; i++) zmem[i] = 16'(16'h3300 + i);
        start_drain(6, t);
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        size_Z = 7'd3;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(60);
        repeat (10) @(posedge clk);
        #1;
        check("t5_done_n", done_n, 1);
        check("t5_beats", beat_n, 6);
        check("t5_reads", rd_n, 6);
        check("t5_last_rd_addr", last_rd_addr, 5);
        check("t5_done_cyc", done_cyc, t + 9);
        check("t5_sb_empty", sb.size(), 0);

        // reset after 3 of 10 beats, then a fresh drain
        for (int i = 0; i < 10; i++) zmem[i] = 16'(16'h5500 + i);
        start_drain(10, t);
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (beat_n >= 3) break;
        end
        check("t6_three_beats_seen", beat_n >= 3, 1);
        rstn = 1'b0;
        sb.delete();
        @(negedge clk);
        check_outputs_zero("t6_midreset");
        check("t6_beats_at_reset", beat_n, 3);
        @(posedge clk); #1;
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) zmem[i] = 16'(16'h7700 + i);
        start_drain(4, t);
        wait_done(40);
        check("t6_first_rd_cyc", first_rd_cyc, t + 1);
        check("t6_beats", beat_n, 4);
        check("t6_reads", rd_n, 4);
        check("t6_done_n", done_n, 1);
        check("t6_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
